// File: rtl/global_buffer_pkg.sv
// Shared types and constants for the global-buffer tile event pipe.
// Holds the per-channel FSM state encoding, the event channel indices and
// the default column fan-out of a global buffer tile.
package global_buffer_pkg;

    // Event channel indices
    localparam int unsigned CH_STRM_F2G = 0;
    localparam int unsigned CH_STRM_G2F = 1;
    localparam int unsigned CH_PCFG     = 2;
    localparam int unsigned NUM_EVT_CH  = CH_PCFG + 1;

    // CGRA columns served by one global buffer tile
    localparam int unsigned CGRA_PER_GLB = 4;

    // Per-channel event FSM state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

endpackage : global_buffer_pkg

// File: rtl/glb_pulse_delay.sv
// Fixed-latency shift register used for every delayed path of the event pipe.
// Advances only while i_en is high; the async active-low clear empties
// every stage so nothing in flight survives a reset.
//   clk     in   clock
//   rst_n   in   asynchronous active-low clear
//   i_en    in   shift enable
//   i_data  in   WIDTH  value entering stage 1
//   o_data  out  WIDTH  value leaving stage DEPTH
module glb_pulse_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0][WIDTH-1:0] r_stage;

    // Shift chain; stage 0 captures the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else if (i_en) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule : glb_pulse_delay

// File: rtl/glb_tile_event_pipe.sv
// Global buffer tile event pipe: distributes the CGRA stall to the columns
// and runs one IDLE/BUSY/DONE handshake FSM per event channel, forwarding
// accepted starts to the core and turning completions into interrupts.
// Stall, start and interrupt paths share a PIPE_DEPTH (legal 1..4) delay.
//   clk              in   clock
//   reset_n          in   asynchronous active-low reset
//   clk_en           in   global clock enable, all state holds when 0
//   cgra_stall_in    in   global stall request
//   cfg_stall_mask   in   NUM_COL  1 = column ignores stall
//   cgra_stall       out  NUM_COL  per-column stall
//   start_pulse_in   in   NUM_CH   start triggers
//   start_pulse_out  out  NUM_CH   delayed accepted starts
//   done_pulse_in    in   NUM_CH   completion pulses from core
//   irq_ack          in   NUM_CH   interrupt acknowledge (level)
//   interrupt_pulse  out  NUM_CH   one-cycle interrupt per completion
//   irq_pending      out  NUM_CH   sticky pending flag
//   ch_busy          out  NUM_CH   channel in BUSY
//   overrun_cnt      out  NUM_CH x CNT_WIDTH  saturating rejected-start count
module glb_tile_event_pipe
    import global_buffer_pkg::*;
#(
    parameter int unsigned NUM_CH     = NUM_EVT_CH,
    parameter int unsigned NUM_COL    = CGRA_PER_GLB,
    parameter int unsigned PIPE_DEPTH = 1,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clk_en,
    input  logic                               cgra_stall_in,
    input  logic [NUM_COL-1:0]                 cfg_stall_mask,
    output logic [NUM_COL-1:0]                 cgra_stall,
    input  logic [NUM_CH-1:0]                  start_pulse_in,
    output logic [NUM_CH-1:0]                  start_pulse_out,
    input  logic [NUM_CH-1:0]                  done_pulse_in,
    input  logic [NUM_CH-1:0]                  irq_ack,
    output logic [NUM_CH-1:0]                  interrupt_pulse,
    output logic [NUM_CH-1:0]                  irq_pending,
    output logic [NUM_CH-1:0]                  ch_busy,
    output logic [NUM_CH-1:0][CNT_WIDTH-1:0]   overrun_cnt
);

    ch_state_e                      r_state     [NUM_CH];
    ch_state_e                      w_state_nxt [NUM_CH];
    logic [NUM_CH-1:0]              w_start_acc;
    logic [NUM_CH-1:0]              w_done_acc;
    logic [NUM_CH-1:0]              w_overrun;
    logic [NUM_COL-1:0]             w_stall_req;
    logic [NUM_CH-1:0]              r_irq_pending;
    logic [NUM_CH-1:0]              r_ch_busy;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] r_overrun_cnt;

    // Mask is applied before stage 1 so a mask change follows the stall latency
    assign w_stall_req = {NUM_COL{cgra_stall_in}} & ~cfg_stall_mask;

    glb_pulse_delay #(
        .WIDTH (NUM_COL),
        .DEPTH (PIPE_DEPTH)
    ) u_stall_dly (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_en   (clk_en),
        .i_data (w_stall_req),
        .o_data (cgra_stall)
    );

    glb_pulse_delay #(
        .WIDTH (NUM_CH),
        .DEPTH (PIPE_DEPTH)
    ) u_start_dly (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_en   (clk_en),
        .i_data (w_start_acc),
        .o_data (start_pulse_out)
    );

    glb_pulse_delay #(
        .WIDTH (NUM_CH),
        .DEPTH (PIPE_DEPTH)
    ) u_irq_dly (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_en   (clk_en),
        .i_data (w_done_acc),
        .o_data (interrupt_pulse)
    );

    // Next-state and event decode, independent per channel
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            w_state_nxt[c] = r_state[c];
            w_start_acc[c] = 1'b0;
            w_done_acc[c]  = 1'b0;
            w_overrun[c]   = 1'b0;
            case (r_state[c])
                ST_IDLE: begin
                    if (start_pulse_in[c]) begin
                        w_state_nxt[c] = ST_BUSY;
                        w_start_acc[c] = 1'b1;
                    end
                end
                ST_BUSY: begin
                    // A start arriving with the done is still a rejected start
                    w_overrun[c] = start_pulse_in[c];
                    if (done_pulse_in[c]) begin
                        w_state_nxt[c] = ST_DONE;
                        w_done_acc[c]  = 1'b1;
                    end
                end
                ST_DONE: begin
                    // Ack with start is treated as ack first, then a fresh start
                    if (irq_ack[c]) begin
                        w_state_nxt[c] = start_pulse_in[c] ? ST_BUSY : ST_IDLE;
                        w_start_acc[c] = start_pulse_in[c];
                    end else begin
                        w_overrun[c] = start_pulse_in[c];
                    end
                end
                default: begin
                    w_state_nxt[c] = ST_IDLE;
                end
            endcase
        end
    end

    // State, flags and saturating overrun counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                r_state[c] <= ST_IDLE;
            end
            r_irq_pending <= '0;
            r_ch_busy     <= '0;
            r_overrun_cnt <= '0;
        end else if (clk_en) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                r_state[c]       <= w_state_nxt[c];
                r_irq_pending[c] <= (w_state_nxt[c] == ST_DONE);
                r_ch_busy[c]     <= (w_state_nxt[c] == ST_BUSY);
                if (w_overrun[c] && (r_overrun_cnt[c] != {CNT_WIDTH{1'b1}})) begin
                    r_overrun_cnt[c] <= r_overrun_cnt[c] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign irq_pending = r_irq_pending;
    assign ch_busy     = r_ch_busy;
    assign overrun_cnt = r_overrun_cnt;

endmodule : glb_tile_event_pipe

// File: tb/tb_glb_tile_event_pipe.sv
// Self-checking bench for glb_tile_event_pipe: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_glb_tile_event_pipe;
    import global_buffer_pkg::*;

    localparam int D    = 2;
    localparam int NC   = 3;
    localparam int NCOL = 4;
    localparam int CW   = 8;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    clk_en;
    logic                    cgra_stall_in;
    logic [NCOL-1:0]         cfg_stall_mask;
    logic [NCOL-1:0]         cgra_stall;
    logic [NC-1:0]           start_pulse_in;
    logic [NC-1:0]           start_pulse_out;
    logic [NC-1:0]           done_pulse_in;
    logic [NC-1:0]           irq_ack;
    logic [NC-1:0]           interrupt_pulse;
    logic [NC-1:0]           irq_pending;
    logic [NC-1:0]           ch_busy;
    logic [NC-1:0][CW-1:0]   overrun_cnt;

    glb_tile_event_pipe #(
        .NUM_CH     (NC),
        .NUM_COL    (NCOL),
        .PIPE_DEPTH (D),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clk_en          (clk_en),
        .cgra_stall_in   (cgra_stall_in),
        .cfg_stall_mask  (cfg_stall_mask),
        .cgra_stall      (cgra_stall),
        .start_pulse_in  (start_pulse_in),
        .start_pulse_out (start_pulse_out),
        .done_pulse_in   (done_pulse_in),
        .irq_ack         (irq_ack),
        .interrupt_pulse (interrupt_pulse),
        .irq_pending     (irq_pending),
        .ch_busy         (ch_busy),
        .overrun_cnt     (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: busy/pending flags, counters, and queues of
    // events scheduled to appear D enabled edges after they are accepted
    logic [NC-1:0]         m_busy;
    logic [NC-1:0]         m_pend;
    logic [NC-1:0][CW-1:0] m_cnt;
    logic [NCOL-1:0]       q_stall [$];
    logic [NC-1:0]         q_start [$];
    logic [NC-1:0]         q_irq   [$];
    int                    sp_seen [NC];
    logic [NC-1:0]         pulse_or;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_pend = '0;
        m_cnt  = '0;
        q_stall.delete();
        q_start.delete();
        q_irq.delete();
        for (int i = 0; i < D; i++) begin
            q_stall.push_back('0);
            q_start.push_back('0);
            q_irq.push_back('0);
        end
    endtask

    task automatic model_edge();
        logic [NC-1:0] acc_s;
        logic [NC-1:0] acc_d;
        acc_s = '0;
        acc_d = '0;
        if (!reset_n || !clk_en) return;
        for (int c = 0; c < NC; c++) begin
            if (m_busy[c]) begin
                if (done_pulse_in[c]) begin
                    m_busy[c] = 1'b0;
                    m_pend[c] = 1'b1;
                    acc_d[c]  = 1'b1;
                end
                if (start_pulse_in[c] && m_cnt[c] != 8'hFF) m_cnt[c] = m_cnt[c] + 8'd1;
            end else if (m_pend[c]) begin
                if (irq_ack[c]) begin
                    m_pend[c] = 1'b0;
                    if (start_pulse_in[c]) begin
                        m_busy[c] = 1'b1;
                        acc_s[c]  = 1'b1;
                    end
                end else if (start_pulse_in[c] && m_cnt[c] != 8'hFF) begin
                    m_cnt[c] = m_cnt[c] + 8'd1;
                end
            end else if (start_pulse_in[c]) begin
                m_busy[c] = 1'b1;
                acc_s[c]  = 1'b1;
            end
        end
        q_stall.push_back(cgra_stall_in ? ~cfg_stall_mask : 4'b0000);
        q_start.push_back(acc_s);
        q_irq.push_back(acc_d);
        void'(q_stall.pop_front());
        void'(q_start.pop_front());
        void'(q_irq.pop_front());
    endtask

    task automatic check_all();
        check("stall",   64'(cgra_stall),      64'(q_stall[0]));
        check("sp_out",  64'(start_pulse_out), 64'(q_start[0]));
        check("irq",     64'(interrupt_pulse), 64'(q_irq[0]));
        check("pending", 64'(irq_pending),     64'(m_pend));
        check("busy",    64'(ch_busy),         64'(m_busy));
        check("overrun", 64'(overrun_cnt),     64'(m_cnt));
    endtask

    // One clock: inputs were set before the edge, outputs sampled 1 unit after
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
        if (reset_n && clk_en) begin
            for (int c = 0; c < NC; c++) if (start_pulse_out[c]) sp_seen[c]++;
        end
        pulse_or = pulse_or | start_pulse_out | interrupt_pulse;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_all_zero",
              64'({cgra_stall, start_pulse_out, interrupt_pulse, irq_pending, ch_busy, overrun_cnt}),
              64'(0));
        repeat (cycles) step();
        reset_n = 1'b1;
    endtask

    task automatic clear_inputs();
        start_pulse_in = '0;
        done_pulse_in  = '0;
        irq_ack        = '0;
    endtask

    initial begin
        reset_n        = 1'b0;
        clk_en         = 1'b1;
        cgra_stall_in  = 1'b0;
        cfg_stall_mask = '0;
        clear_inputs();
        pulse_or = '0;
        for (int c = 0; c < NC; c++) sp_seen[c] = 0;
        model_reset();
        #2;
        do_reset(3);

        // Stall fan-out with one masked column
        cfg_stall_mask = 4'b0010;
        repeat (3) step();
        cgra_stall_in = 1'b1;
        step();
        check("stall_before_D", 64'(cgra_stall), 64'(4'b0000));
        step();
        check("stall_at_D", 64'(cgra_stall), 64'(4'b1101));
        step();
        check("stall_held", 64'(cgra_stall), 64'(4'b1101));
        cgra_stall_in = 1'b0;
        repeat (D + 1) step();
        check("stall_released", 64'(cgra_stall), 64'(4'b0000));

        // ch0 full handshake: start, done, ack
        start_pulse_in[CH_STRM_F2G] = 1'b1;
        step();
        start_pulse_in = '0;
        check("ch0_busy", 64'(ch_busy[CH_STRM_F2G]), 64'(1));
        check("ch0_sp_early", 64'(start_pulse_out[CH_STRM_F2G]), 64'(0));
        step();
        check("ch0_sp_at_D", 64'(start_pulse_out[CH_STRM_F2G]), 64'(1));
        step();
        check("ch0_sp_one_cycle", 64'(start_pulse_out[CH_STRM_F2G]), 64'(0));
        repeat (12) step();
        done_pulse_in[CH_STRM_F2G] = 1'b1;
        step();
        done_pulse_in = '0;
        check("ch0_pend_set", 64'(irq_pending[CH_STRM_F2G]), 64'(1));
        check("ch0_irq_early", 64'(interrupt_pulse[CH_STRM_F2G]), 64'(0));
        step();
        check("ch0_irq_at_D", 64'(interrupt_pulse[CH_STRM_F2G]), 64'(1));
        step();
        check("ch0_irq_one_cycle", 64'(interrupt_pulse[CH_STRM_F2G]), 64'(0));
        repeat (7) step();
        check("ch0_pend_held", 64'(irq_pending[CH_STRM_F2G]), 64'(1));
        irq_ack[CH_STRM_F2G] = 1'b1;
        step();
        irq_ack = '0;
        check("ch0_idle_pend", 64'(irq_pending[CH_STRM_F2G]), 64'(0));
        check("ch0_idle_busy", 64'(ch_busy[CH_STRM_F2G]), 64'(0));

        // ch1 overrun saturation
        for (int c = 0; c < NC; c++) sp_seen[c] = 0;
        start_pulse_in[CH_STRM_G2F] = 1'b1;
        step();
        repeat (300) step();
        start_pulse_in = '0;
        repeat (D + 1) step();
        check("ch1_ovr_sat", 64'(overrun_cnt[CH_STRM_G2F]), 64'(8'hFF));
        check("ch1_one_start", 64'(sp_seen[CH_STRM_G2F]), 64'(1));
        done_pulse_in[CH_STRM_G2F] = 1'b1;
        step();
        done_pulse_in = '0;
        irq_ack[CH_STRM_G2F] = 1'b1;
        step();
        irq_ack = '0;

        // ch2 ack and start together in DONE
        start_pulse_in[CH_PCFG] = 1'b1;
        step();
        start_pulse_in = '0;
        done_pulse_in[CH_PCFG] = 1'b1;
        step();
        done_pulse_in = '0;
        repeat (4) step();
        for (int c = 0; c < NC; c++) sp_seen[c] = 0;
        irq_ack[CH_PCFG]        = 1'b1;
        start_pulse_in[CH_PCFG] = 1'b1;
        step();
        clear_inputs();
        check("ch2_rebusy", 64'(ch_busy[CH_PCFG]), 64'(1));
        check("ch2_pend_clr", 64'(irq_pending[CH_PCFG]), 64'(0));
        check("ch2_ovr_none", 64'(overrun_cnt[CH_PCFG]), 64'(0));
        repeat (D + 2) step();
        check("ch2_one_start", 64'(sp_seen[CH_PCFG]), 64'(1));

        // Frozen clock enable drops starts, then reset with a done in flight
        clk_en = 1'b0;
        start_pulse_in = '1;
        repeat (3) step();
        check("frz_sp", 64'(start_pulse_out), 64'(0));
        check("frz_busy", 64'(ch_busy), 64'(3'b100));
        clk_en = 1'b1;
        start_pulse_in = '0;
        start_pulse_in[CH_STRM_F2G] = 1'b1;
        step();
        start_pulse_in = '0;
        done_pulse_in[CH_STRM_F2G] = 1'b1;
        step();
        done_pulse_in = '0;
        do_reset(2);
        pulse_or = '0;
        repeat (D + 4) step();
        check("post_rst_no_pulse", 64'(pulse_or), 64'(0));
        check("post_rst_zero",
              64'({cgra_stall, irq_pending, ch_busy, overrun_cnt}), 64'(0));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1);
            end else begin
                clk_en         = ($urandom_range(0, 9) != 0);
                cgra_stall_in  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) cfg_stall_mask = 4'($urandom);
                start_pulse_in = 3'($urandom) & 3'($urandom);
                done_pulse_in  = 3'($urandom) & 3'($urandom);
                irq_ack        = 3'($urandom);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_glb_tile_event_pipe

// File: doc/glb_tile_event_pipe.md
GLB_TILE_EVENT_PIPE -- requirements
Module: glb_tile_event_pipe

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning event channels (0 strm_f2g, 1 strm_g2f, 2 pcfg).
REQ-002 SHALL have parameter NUM_COL, default CGRA_PER_GLB, meaning stall fan-out columns.
REQ-003 SHALL have parameter PIPE_DEPTH, default 1, legal 1..4, meaning register stages on stall/start/interrupt paths.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, meaning overrun counter width.
REQ-005 SHALL have clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
REQ-006 SHALL have these remaining ports:
- clk_en  in  1  global clock enable; all state holds when 0
- cgra_stall_in  in  1  global stall request
- cfg_stall_mask  in  NUM_COL  1 = column ignores stall
- cgra_stall  out  NUM_COL  per-column stall
- start_pulse_in  in  NUM_CH  start triggers
- start_pulse_out  out  NUM_CH  delayed accepted starts to core
- done_pulse_in  in  NUM_CH  completion pulses from core
- irq_ack  in  NUM_CH  interrupt acknowledge, level sampled
- interrupt_pulse  out  NUM_CH  one-cycle interrupt per completion
- irq_pending  out  NUM_CH  sticky pending flag
- ch_busy  out  NUM_CH  channel in BUSY
- overrun_cnt  out  NUM_CH x CNT_WIDTH  rejected-start count

Function
REQ-007 SHALL drive cgra_stall[i] = cgra_stall_in & ~cfg_stall_mask[i], delayed exactly PIPE_DEPTH enabled cycles; mask is sampled at stage 1.
REQ-008 SHALL keep per-channel FSM with states IDLE, BUSY, DONE.
REQ-009 SHALL transition IDLE->BUSY on start_pulse_in; start_pulse_out asserts PIPE_DEPTH cycles after that start.
REQ-010 SHALL transition BUSY->DONE on done_pulse_in and set irq_pending at the next edge.
REQ-011 SHALL assert interrupt_pulse for exactly one cycle, PIPE_DEPTH cycles after the accepted done_pulse_in.
REQ-012 SHALL transition DONE->IDLE on irq_ack and clear irq_pending.
REQ-013 SHALL treat irq_ack and start_pulse_in together in DONE as ack-then-start: go to BUSY, clear irq_pending, forward the start.
REQ-014 SHALL reject start_pulse_in in BUSY, or in DONE without ack: no forward, no state change, overrun_cnt increments.
REQ-015 SHALL treat start and done together in BUSY as: go to DONE and count the start as an overrun.
REQ-016 SHALL ignore done_pulse_in in IDLE or DONE, and irq_ack in IDLE or BUSY.
REQ-017 SHALL saturate overrun_cnt at all-ones; it is cleared only by reset.
REQ-018 SHALL drive ch_busy = (state==BUSY), registered with state.
REQ-019 SHALL, when clk_en=0, freeze all registers, including pipeline stages; pulses presented then are dropped.
REQ-020 SHALL have channels that are fully independent; no cross-channel priority.

Reset
REQ-021 SHALL, on reset_n low, immediately clear all outputs to 0, all FSMs to IDLE, all pipeline stages and counters to 0, regardless of clk_en.
REQ-022 SHALL discard in-flight pulses on reset mid-operation; no pulse emerges after reset_n deasserts.

Structure
REQ-023 SHALL place the FSM state enum (IDLE/BUSY/DONE) and channel-index localparams in global_buffer_pkg.
REQ-024 SHALL use one sub-module, glb_pulse_delay (WIDTH, DEPTH, clk_en-gated shift register with async active-low clear), for all three delayed paths.

Verification
REQ-025 SHALL check, with PIPE_DEPTH=2, cfg_stall_mask=4'b0010 and cgra_stall_in raised at cycle 10: cgra_stall=4'b1101 from cycle 12.
REQ-026 SHALL check start ch0 at t=5, done at t=20 and ack at t=30:
- start_pulse_out at t=5+PIPE_DEPTH
- irq_pending 21..30
- interrupt_pulse at 20+PIPE_DEPTH
- ch0 IDLE at t=31
REQ-027 SHALL check 300 starts on ch1 while BUSY (CNT_WIDTH=8): overrun_cnt=255 and no extra start_pulse_out.
REQ-028 SHALL check ack+start in DONE for ch2: state BUSY, irq_pending 0, exactly one start_pulse_out.
REQ-029 SHALL check start pulses with clk_en=0 for 3 cycles, then reset_n low mid-BUSY with a done in flight:
- no start_pulse_out or interrupt_pulse afterward
- all outputs 0
